// File: rtl/ctrl_decode_reg.sv
// Registered control decode for the ARM-subset pipeline: decodes op/mode/cond against NZCV,
// issues EX controls one cycle later, and squashes the branch shadow.
module ctrl_decode_reg #(
    parameter int CMD_W  = 4,
    parameter int SHADOW = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             stall,
    input  logic             flush,
    input  logic [3:0]       op_code,
    input  logic [1:0]       mode,
    input  logic             s_in,
    input  logic [3:0]       cond,
    input  logic [3:0]       sr,
    output logic             out_valid,
    output logic [CMD_W-1:0] exe_cmd,
    output logic             mem_r_en,
    output logic             mem_w_en,
    output logic             wb_en,
    output logic             s,
    output logic             b,
    output logic             squashed
);

    localparam logic [2:0] SHADOW_LD = 3'(SHADOW);

    logic [3:0] dec_cmd;
    logic       dec_mr, dec_mw, dec_wb, dec_s, dec_b, dec_def;
    logic       pass;
    logic       issue;
    logic [2:0] shadow_cnt;

    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'b0000: cond_pass = z;
            4'b0001: cond_pass = !z;
            4'b0010: cond_pass = cy;
            4'b0011: cond_pass = !cy;
            4'b0100: cond_pass = n;
            4'b0101: cond_pass = !n;
            4'b0110: cond_pass = v;
            4'b0111: cond_pass = !v;
            4'b1000: cond_pass = cy && !z;
            4'b1001: cond_pass = !cy || z;
            4'b1010: cond_pass = (n == v);
            4'b1011: cond_pass = (n != v);
            4'b1100: cond_pass = !z && (n == v);
            4'b1101: cond_pass = z || (n != v);
            default: cond_pass = 1'b1;
        endcase
    endfunction

    always_comb begin
        dec_cmd = 4'b0000;
        dec_mr  = 1'b0;
        dec_mw  = 1'b0;
        dec_wb  = 1'b0;
        dec_s   = 1'b0;
        dec_b   = 1'b0;
        dec_def = 1'b0;
        case (mode)
            2'b00: begin
                dec_def = 1'b1;
                dec_wb  = 1'b1;
                dec_s   = s_in;
                case (op_code)
                    4'b1101: dec_cmd = 4'b0001;
                    4'b1111: dec_cmd = 4'b1001;
                    4'b0100: dec_cmd = 4'b0010;
                    4'b0101: dec_cmd = 4'b0011;
                    4'b0010: dec_cmd = 4'b0100;
                    4'b0110: dec_cmd = 4'b0101;
                    4'b0000: dec_cmd = 4'b0110;
                    4'b1100: dec_cmd = 4'b0111;
                    4'b0001: dec_cmd = 4'b1000;
                    // Compare/test only set flags: no writeback, S forced on.
                    4'b1010: begin
                        dec_cmd = 4'b0100;
                        dec_wb  = 1'b0;
                        dec_s   = 1'b1;
                    end
                    4'b1000: begin
                        dec_cmd = 4'b0110;
                        dec_wb  = 1'b0;
                        dec_s   = 1'b1;
                    end
                    default: begin
                        dec_def = 1'b0;
                        dec_wb  = 1'b0;
                        dec_s   = 1'b0;
                    end
                endcase
            end
            2'b01: begin
                dec_def = 1'b1;
                dec_cmd = 4'b0010;
                if (s_in) begin
                    dec_mr = 1'b1;
                    dec_wb = 1'b1;
                end else begin
                    dec_mw = 1'b1;
                end
            end
            2'b10: begin
                dec_def = 1'b1;
                dec_b   = 1'b1;
            end
            default: ;
        endcase
    end

    assign pass  = cond_pass(cond, sr);
    assign issue = dec_def && pass && (shadow_cnt == 3'd0);

    // ID/EX boundary register
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            exe_cmd    <= '0;
            mem_r_en   <= 1'b0;
            mem_w_en   <= 1'b0;
            wb_en      <= 1'b0;
            s          <= 1'b0;
            b          <= 1'b0;
            squashed   <= 1'b0;
            shadow_cnt <= 3'd0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            exe_cmd    <= '0;
            mem_r_en   <= 1'b0;
            mem_w_en   <= 1'b0;
            wb_en      <= 1'b0;
            s          <= 1'b0;
            b          <= 1'b0;
            squashed   <= 1'b0;
            shadow_cnt <= 3'd0;
        end else if (stall) begin
            squashed <= 1'b0;
        end else if (in_valid && issue) begin
            out_valid <= 1'b1;
            exe_cmd   <= CMD_W'(dec_cmd);
            mem_r_en  <= dec_mr;
            mem_w_en  <= dec_mw;
            wb_en     <= dec_wb;
            s         <= dec_s;
            b         <= dec_b;
            squashed  <= 1'b0;
            if (dec_b)
                shadow_cnt <= SHADOW_LD;
        end else begin
            // Squashed accept or idle cycle: both register a bubble.
            out_valid <= 1'b0;
            exe_cmd   <= '0;
            mem_r_en  <= 1'b0;
            mem_w_en  <= 1'b0;
            wb_en     <= 1'b0;
            s         <= 1'b0;
            b         <= 1'b0;
            squashed  <= in_valid;
            if (in_valid && shadow_cnt != 3'd0)
                shadow_cnt <= shadow_cnt - 3'd1;
        end
    end

endmodule

// File: tb/tb_ctrl_decode_reg.sv
// Bench for ctrl_decode_reg: directed test-plan steps then random traffic, checked against
// a table-driven reference model for a SHADOW=2 and a SHADOW=0 instance.
module tb_ctrl_decode_reg;

    typedef struct packed {
        logic       v;
        logic [3:0] cmd;
        logic       mr, mw, wb, s, b, sq;
    } outs_t;

    logic       clk = 1'b0;
    logic       rst, in_valid, stall, flush, s_in;
    logic [3:0] op_code, cond, sr;
    logic [1:0] mode;

    logic       out_valid0, mem_r_en0, mem_w_en0, wb_en0, s0, b0, squashed0;
    logic       out_valid1, mem_r_en1, mem_w_en1, wb_en1, s1, b1, squashed1;
    logic [3:0] exe_cmd0, exe_cmd1;

    int vectors = 0;
    int miscompares = 0;

    outs_t mexp[2];
    int    mshadow[2];
    int    shadow_p[2] = '{2, 0};
    // ALU command per opcode, -1 where the opcode is undefined.
    int    alu_of[16] = '{6, 8, 4, -1, 2, 3, 5, -1, 6, -1, 4, -1, 7, 1, -1, 9};

    always #5 clk = ~clk;

    ctrl_decode_reg #(.CMD_W(4), .SHADOW(2)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
        .op_code(op_code), .mode(mode), .s_in(s_in), .cond(cond), .sr(sr),
        .out_valid(out_valid0), .exe_cmd(exe_cmd0), .mem_r_en(mem_r_en0),
        .mem_w_en(mem_w_en0), .wb_en(wb_en0), .s(s0), .b(b0), .squashed(squashed0)
    );

    ctrl_decode_reg #(.CMD_W(4), .SHADOW(0)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
        .op_code(op_code), .mode(mode), .s_in(s_in), .cond(cond), .sr(sr),
        .out_valid(out_valid1), .exe_cmd(exe_cmd1), .mem_r_en(mem_r_en1),
        .mem_w_en(mem_w_en1), .wb_en(wb_en1), .s(s1), .b(b1), .squashed(squashed1)
    );

    // Conditions come in complementary pairs: odd codes negate the even base test.
    function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        {n, z, cy, v} = f;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy & ~z;
            3'd5: base = (n == v);
            3'd6: base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        return (c[3:1] == 3'd7) ? 1'b1 : (base ^ c[0]);
    endfunction

    function automatic outs_t ref_decode(output logic defined);
        outs_t o;
        o = '0;
        defined = 1'b0;
        o.v = 1'b1;
        if (mode == 2'b00 && alu_of[op_code] >= 0) begin
            defined = 1'b1;
            o.cmd = 4'(alu_of[op_code]);
            if (op_code == 4'b1010 || op_code == 4'b1000) begin
                o.s = 1'b1;
            end else begin
                o.wb = 1'b1;
                o.s  = s_in;
            end
        end else if (mode == 2'b01) begin
            defined = 1'b1;
            o.cmd = 4'b0010;
            o.mr  = s_in;
            o.wb  = s_in;
            o.mw  = ~s_in;
        end else if (mode == 2'b10) begin
            defined = 1'b1;
            o.b = 1'b1;
        end
        return o;
    endfunction

    task automatic model_edge();
        outs_t d;
        logic  def;
        for (int k = 0; k < 2; k++) begin
            if (rst || flush) begin
                mexp[k]    = '0;
                mshadow[k] = 0;
            end else if (stall) begin
                mexp[k].sq = 1'b0;
            end else if (in_valid) begin
                d = ref_decode(def);
                if (def && ref_pass(cond, sr) && mshadow[k] == 0) begin
                    mexp[k] = d;
                    if (mode == 2'b10) mshadow[k] = shadow_p[k];
                end else begin
                    mexp[k]    = '0;
                    mexp[k].sq = 1'b1;
                    if (mshadow[k] > 0) mshadow[k]--;
                end
            end else begin
                mexp[k] = '0;
            end
        end
    endtask

    function automatic outs_t obs0();
        return {out_valid0, exe_cmd0, mem_r_en0, mem_w_en0, wb_en0, s0, b0, squashed0};
    endfunction

    function automatic outs_t obs1();
        return {out_valid1, exe_cmd1, mem_r_en1, mem_w_en1, wb_en1, s1, b1, squashed1};
    endfunction

    task automatic drive(input logic iv, input logic st, input logic fl, input logic [1:0] md,
                         input logic [3:0] op, input logic si, input logic [3:0] cd,
                         input logic [3:0] f);
        in_valid = iv; stall = st; flush = fl; mode = md;
        op_code = op; s_in = si; cond = cd; sr = f;
    endtask

    task automatic step(input string tag);
        outs_t o0, o1;
        @(posedge clk);
        model_edge();
        #1;
        o0 = obs0();
        o1 = obs1();
        vectors++;
        assert (o0 === mexp[0]) else begin
            miscompares++;
            $error("FAIL %s sh2 observed=%b expected=%b", tag, o0, mexp[0]);
        end
        vectors++;
        assert (o1 === mexp[1]) else begin
            miscompares++;
            $error("FAIL %s sh0 observed=%b expected=%b", tag, o1, mexp[1]);
        end
    endtask

    // Hand-derived expectation for the SHADOW=2 instance at a directed point.
    task automatic expect0(input string tag, input outs_t want);
        outs_t o0;
        o0 = obs0();
        vectors++;
        assert (o0 === want) else begin
            miscompares++;
            $error("FAIL %s const observed=%b expected=%b", tag, o0, want);
        end
    endtask

    localparam outs_t ADD_O = 11'b1_0010_0_0_1_1_0_0;
    localparam outs_t SQ_O  = 11'b0_0000_0_0_0_0_0_1;
    localparam outs_t BUB_O = 11'b0_0000_0_0_0_0_0_0;
    localparam outs_t BR_O  = 11'b1_0000_0_0_0_0_1_0;
    localparam outs_t LDR_O = 11'b1_0010_1_0_1_0_0_0;

    initial begin
        mexp[0] = '0; mexp[1] = '0; mshadow[0] = 0; mshadow[1] = 0;
        rst = 1'b1;
        drive(0, 0, 0, 2'b00, 4'h0, 0, 4'hE, 4'h0);
        step("reset");
        step("reset2");
        expect0("reset_state", BUB_O);
        rst = 1'b0;

        drive(1, 0, 0, 2'b00, 4'b0100, 1, 4'hE, 4'h0); step("add");
        expect0("add", ADD_O);
        drive(1, 0, 0, 2'b00, 4'b1010, 0, 4'h0, 4'b0100); step("cmp_eq_pass");
        expect0("cmp_eq_pass", 11'b1_0100_0_0_0_1_0_0);
        drive(1, 0, 0, 2'b00, 4'b1010, 0, 4'h0, 4'b0000); step("cmp_eq_fail");
        expect0("cmp_eq_fail", SQ_O);

        // Branch shadow, back-to-back followers.
        drive(1, 0, 0, 2'b10, 4'h0, 0, 4'hE, 4'h0); step("br");
        expect0("br", BR_O);
        drive(1, 0, 0, 2'b00, 4'b0100, 1, 4'hE, 4'h0); step("shadow1");
        expect0("shadow1", SQ_O);
        step("shadow2");
        expect0("shadow2", SQ_O);
        step("after_shadow");
        expect0("after_shadow", ADD_O);

        // Same with a stall between the first and second follower.
        drive(1, 0, 0, 2'b10, 4'h0, 0, 4'hE, 4'h0); step("br_b");
        drive(1, 0, 0, 2'b00, 4'b0100, 1, 4'hE, 4'h0); step("shadow1_b");
        drive(1, 1, 0, 2'b00, 4'b0100, 1, 4'hE, 4'h0); step("stall_in_shadow");
        expect0("stall_in_shadow", BUB_O);
        drive(1, 0, 0, 2'b00, 4'b0100, 1, 4'hE, 4'h0); step("shadow2_b");
        expect0("shadow2_b", SQ_O);
        step("after_shadow_b");
        expect0("after_shadow_b", ADD_O);

        // LDR held through a 3-cycle stall, then STR.
        drive(1, 0, 0, 2'b01, 4'h0, 1, 4'hE, 4'h0); step("ldr");
        drive(1, 1, 0, 2'b01, 4'h0, 0, 4'hE, 4'h0);
        for (int i = 0; i < 3; i++) begin
            step("ldr_hold");
            expect0("ldr_hold", LDR_O);
        end
        drive(1, 0, 0, 2'b01, 4'h0, 0, 4'hE, 4'h0); step("str");
        expect0("str", 11'b1_0010_0_1_0_0_0_0);

        // Flush plus stall right after a branch.
        drive(1, 0, 0, 2'b10, 4'h0, 0, 4'hE, 4'h0); step("br_c");
        drive(1, 1, 1, 2'b00, 4'b0100, 1, 4'hE, 4'h0); step("flush_stall");
        expect0("flush_stall", BUB_O);
        drive(1, 0, 0, 2'b00, 4'b0100, 1, 4'hE, 4'h0); step("add_after_flush");
        expect0("add_after_flush", ADD_O);

        // Undefined encodings, idle, reset in the shadow window.
        drive(1, 0, 0, 2'b00, 4'b0011, 1, 4'hE, 4'h0); step("undef_op");
        expect0("undef_op", SQ_O);
        drive(1, 0, 0, 2'b11, 4'b0100, 1, 4'hE, 4'h0); step("undef_mode");
        expect0("undef_mode", SQ_O);
        drive(0, 0, 0, 2'b00, 4'b0100, 1, 4'hE, 4'h0); step("idle");
        drive(1, 0, 0, 2'b10, 4'h0, 0, 4'hE, 4'h0); step("br_d");
        rst = 1'b1;
        drive(1, 0, 0, 2'b00, 4'b0100, 1, 4'hE, 4'h0); step("rst_shadow");
        expect0("rst_shadow", BUB_O);
        rst = 1'b0;
        step("add_after_rst");
        expect0("add_after_rst", ADD_O);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            rst      = ($urandom % 60) == 0;
            flush    = ($urandom % 14) == 0;
            stall    = ($urandom % 8) == 0;
            in_valid = ($urandom % 5) != 0;
            mode     = (($urandom % 3) == 0) ? 2'b10 : 2'($urandom);
            op_code  = 4'($urandom);
            s_in     = 1'($urandom);
            cond     = (($urandom % 2) == 0) ? 4'hE : 4'($urandom);
            sr       = 4'($urandom);
            step("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
